// File: rtl/half_adder_if.sv
// Bundles the operand, result and statistics signals of one half_adder
// instance. The master side drives the operands; the slave side is the adder.
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] Cout;
    logic [WIDTH-1:0] Sum;
    logic             out_valid;
    logic             carry_any;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output A, B, in_valid,
        input  Cout, Sum, out_valid, carry_any, carry_cnt
    );

    modport slave (
        input  A, B, in_valid,
        output Cout, Sum, out_valid, carry_any, carry_cnt
    );
endinterface

// File: rtl/half_adder.sv
// Registered, lane-parallel half adder. Each lane adds its own A/B bit pair
// with no carry between lanes; results appear one cycle after a valid input.
// Also reports whether any lane carried and a saturating count of valid
// operations that produced at least one carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    half_adder_if.slave bus
);

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_cout;
    logic             carry_now;

    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] cout_reg;
    logic             out_valid_reg;
    logic             carry_any_reg;
    logic [CNT_W-1:0] carry_cnt_reg;
    logic [CNT_W-1:0] carry_cnt_next;

    // Per-lane combinational half adder: {cout,sum} = a + b.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign lane_sum[gi]  = bus.A[gi] ^ bus.B[gi];
            assign lane_cout[gi] = bus.A[gi] & bus.B[gi];
        end
    endgenerate

    assign carry_now = |lane_cout;

    // Saturating carry-event counter: stops at all-ones instead of wrapping.
    always_comb begin
        carry_cnt_next = carry_cnt_reg;
        if (bus.in_valid && carry_now && !(&carry_cnt_reg)) begin
            carry_cnt_next = carry_cnt_reg + CNT_W'(1);
        end
    end

    // Result registers: capture on valid, hold otherwise; reset wins.
    // Operands are only looked at when in_valid is high, so idle X/Z on A/B
    // cannot reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            cout_reg      <= '0;
            out_valid_reg <= 1'b0;
            carry_any_reg <= 1'b0;
            carry_cnt_reg <= '0;
        end else begin
            out_valid_reg <= bus.in_valid;
            carry_cnt_reg <= carry_cnt_next;
            if (bus.in_valid) begin
                sum_reg       <= lane_sum;
                cout_reg      <= lane_cout;
                carry_any_reg <= carry_now;
            end
        end
    end

    assign bus.Sum       = sum_reg;
    assign bus.Cout      = cout_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.carry_any = carry_any_reg;
    assign bus.carry_cnt = carry_cnt_reg;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a single-lane instance with a narrow counter (so
// saturation is reachable) and a four-lane instance for lane independence
// and a long random back-to-back stream.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    half_adder_if #(.WIDTH(1), .CNT_W(3))  nif ();
    half_adder_if #(.WIDTH(4), .CNT_W(16)) wif ();

    half_adder #(.WIDTH(1), .CNT_W(3)) u_narrow (
        .clk (clk),
        .rst (rst),
        .bus (nif)
    );

    half_adder #(.WIDTH(4), .CNT_W(16)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    typedef struct packed {
        logic [3:0] sum;
        logic [3:0] cout;
        logic       any;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        nif.in_valid = 1'b0;
        wif.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // (A,B) = 00,01,10,11, two cycles each, against the half-adder truth table.
    task automatic test_sweep();
        logic [1:0] tbl [4];
        exp_t       e;
        exp_t       got;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10};
        do_reset();
        n_vec++;
        if ({nif.out_valid, nif.Cout, nif.Sum, nif.carry_cnt} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b cout=%b sum=%b cnt=%0d, want all zero",
                     nif.out_valid, nif.Cout, nif.Sum, nif.carry_cnt);
        end
        for (int p = 0; p < 4; p++) begin
            for (int r = 0; r < 2; r++) begin
                @(negedge clk);
                nif.in_valid = 1'b1;
                nif.A        = (p >= 2) ? 1'b1 : 1'b0;
                nif.B        = (p % 2 == 1) ? 1'b1 : 1'b0;
                e.sum  = {3'b000, tbl[p][0]};
                e.cout = {3'b000, tbl[p][1]};
                e.any  = tbl[p][1];
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                n_vec++;
                if (nif.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL sweep_valid: A=%b B=%b out_valid=%b, want 1",
                             nif.A, nif.B, nif.out_valid);
                end else begin
                    e   = exp_q.pop_front();
                    got = '{sum: {3'b000, nif.Sum}, cout: {3'b000, nif.Cout}, any: nif.carry_any};
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL sweep: A=%b B=%b got cout,sum=%b%b any=%b want %b%b any=%b",
                                 nif.A, nif.B, nif.Cout, nif.Sum, nif.carry_any,
                                 e.cout[0], e.sum[0], e.any);
                    end else begin
                        $display("sweep A=%b B=%b -> cout=%b sum=%b", nif.A, nif.B, nif.Cout, nif.Sum);
                    end
                end
            end
        end
        @(negedge clk);
        nif.in_valid = 1'b0;
    endtask

    // Reset asserted together with a valid carry op: reset must win.
    task automatic test_reset();
        @(negedge clk);
        nif.in_valid = 1'b1;
        nif.A        = 1'b1;
        nif.B        = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({nif.Cout, nif.out_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_pre: cout=%b ov=%b want 1 1", nif.Cout, nif.out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({nif.Cout, nif.Sum, nif.out_valid, nif.carry_any} !== 4'b0 || nif.carry_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_wins: cout=%b sum=%b ov=%b any=%b cnt=%0d want all zero",
                     nif.Cout, nif.Sum, nif.out_valid, nif.carry_any, nif.carry_cnt);
        end else begin
            $display("reset with in_valid=1 A=1 B=1 -> cleared");
        end
        @(negedge clk);
        rst          = 1'b0;
        nif.in_valid = 1'b0;
    endtask

    // Valid 1+1 then idle cycles: results hold, out_valid drops, idle X/Z ignored.
    task automatic test_hold();
        do_reset();
        @(negedge clk);
        nif.in_valid = 1'b1;
        nif.A        = 1'b1;
        nif.B        = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({nif.Cout, nif.Sum, nif.out_valid, nif.carry_any} !== 4'b1011) begin
            n_err++;
            $display("FAIL hold_load: cout=%b sum=%b ov=%b any=%b want 1 0 1 1",
                     nif.Cout, nif.Sum, nif.out_valid, nif.carry_any);
        end
        @(negedge clk);
        nif.in_valid = 1'b0;
        nif.A        = 1'b0;
        nif.B        = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({nif.Cout, nif.Sum, nif.out_valid, nif.carry_any} !== 4'b1001) begin
            n_err++;
            $display("FAIL hold_idle: cout=%b sum=%b ov=%b any=%b want 1 0 0 1",
                     nif.Cout, nif.Sum, nif.out_valid, nif.carry_any);
        end
        @(negedge clk);
        nif.A = 1'bx;
        nif.B = 1'bz;
        @(posedge clk);
        #1;
        n_vec++;
        if ({nif.Cout, nif.Sum, nif.out_valid, nif.carry_any} !== 4'b1001 || nif.carry_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL hold_xz: cout=%b sum=%b ov=%b any=%b cnt=%0d want 1 0 0 1 cnt=1",
                     nif.Cout, nif.Sum, nif.out_valid, nif.carry_any, nif.carry_cnt);
        end else begin
            $display("hold: idle with A=0/x B=1/z keeps cout=1 sum=0");
        end
        nif.A = 1'b0;
        nif.B = 1'b0;
    endtask

    // Four independent lanes: no carry may ripple between lanes.
    task automatic test_lanes();
        @(negedge clk);
        wif.in_valid = 1'b1;
        wif.A        = 4'b1100;
        wif.B        = 4'b1010;
        @(posedge clk);
        #1;
        n_vec++;
        if (wif.Sum !== 4'b0110 || wif.Cout !== 4'b1000 || wif.carry_any !== 1'b1 || wif.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL lanes: sum=%b cout=%b any=%b ov=%b want 0110 1000 1 1",
                     wif.Sum, wif.Cout, wif.carry_any, wif.out_valid);
        end else begin
            $display("lanes A=1100 B=1010 -> sum=%b cout=%b any=%b", wif.Sum, wif.Cout, wif.carry_any);
        end
        @(negedge clk);
        wif.A = 4'b0101;
        wif.B = 4'b1010;
        @(posedge clk);
        #1;
        n_vec++;
        if (wif.Sum !== 4'b1111 || wif.Cout !== 4'b0000 || wif.carry_any !== 1'b0) begin
            n_err++;
            $display("FAIL lanes_nocarry: sum=%b cout=%b any=%b want 1111 0000 0",
                     wif.Sum, wif.Cout, wif.carry_any);
        end
        @(negedge clk);
        wif.in_valid = 1'b0;
    endtask

    // Carry counter: counts only valid carrying ops, then saturates at 7.
    task automatic test_counter();
        logic [2:0] ops [5];
        logic [2:0] model;
        ops   = '{3'b111, 3'b111, 3'b101, 3'b011, 3'b111};
        model = 3'd0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nif.in_valid = ops[i][2];
            nif.A        = ops[i][1];
            nif.B        = ops[i][0];
            if (ops[i] == 3'b111 && model != 3'd7) model = model + 3'd1;
            @(posedge clk);
            #1;
            n_vec++;
            if (nif.carry_cnt !== model) begin
                n_err++;
                $display("FAIL cnt_step%0d: v=%b A=%b B=%b cnt=%0d want %0d",
                         i, ops[i][2], ops[i][1], ops[i][0], nif.carry_cnt, model);
            end
        end
        n_vec++;
        if (nif.carry_cnt !== 3'd3) begin
            n_err++;
            $display("FAIL cnt_three: cnt=%0d want 3", nif.carry_cnt);
        end else begin
            $display("counter after 3 carrying ops -> %0d", nif.carry_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nif.in_valid = 1'b1;
            nif.A        = 1'b1;
            nif.B        = 1'b1;
            if (model != 3'd7) model = model + 3'd1;
            @(posedge clk);
            #1;
            n_vec++;
            if (nif.carry_cnt !== model) begin
                n_err++;
                $display("FAIL cnt_sat_step%0d: cnt=%0d want %0d", i, nif.carry_cnt, model);
            end
        end
        n_vec++;
        if (nif.carry_cnt !== 3'd7) begin
            n_err++;
            $display("FAIL cnt_saturate: cnt=%0d want 7", nif.carry_cnt);
        end else begin
            $display("counter saturated at %0d", nif.carry_cnt);
        end
        @(negedge clk);
        nif.in_valid = 1'b0;
    endtask

    // 1000 back-to-back random ops through the scoreboard on the wide instance.
    task automatic test_back_to_back();
        exp_t        e;
        exp_t        got;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] cnt_model;
        int          bad;
        do_reset();
        cnt_model = 16'd0;
        bad       = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            wif.in_valid = 1'b1;
            wif.A        = a;
            wif.B        = b;
            e.sum  = a ^ b;
            e.cout = a & b;
            e.any  = (a & b) != 4'b0000;
            if (e.any && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            n_vec++;
            if (wif.out_valid !== 1'b1) begin
                n_err++;
                bad++;
                $display("FAIL b2b_valid op%0d: out_valid=%b want 1", i, wif.out_valid);
            end else begin
                e   = exp_q.pop_front();
                got = '{sum: wif.Sum, cout: wif.Cout, any: wif.carry_any};
                if (got !== e) begin
                    n_err++;
                    bad++;
                    $display("FAIL b2b op%0d: A=%b B=%b got sum=%b cout=%b any=%b want %b %b %b",
                             i, a, b, wif.Sum, wif.Cout, wif.carry_any, e.sum, e.cout, e.any);
                end
            end
        end
        @(negedge clk);
        wif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (wif.out_valid !== 1'b0 || wif.carry_cnt !== cnt_model || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_end: ov=%b cnt=%0d want ov=0 cnt=%0d, queue left=%0d",
                     wif.out_valid, wif.carry_cnt, cnt_model, exp_q.size());
        end
        $display("back_to_back: 1000 ops, %0d bad, carry_cnt=%0d", bad, wif.carry_cnt);
    endtask

    initial begin
        rst          = 1'b1;
        nif.in_valid = 1'b0;
        nif.A        = '0;
        nif.B        = '0;
        wif.in_valid = 1'b0;
        wif.A        = '0;
        wif.B        = '0;
        test_sweep();
        test_reset();
        test_hold();
        test_lanes();
        test_counter();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
